nmea_lat_parser: RTL and testbench

Streaming NMEA-0183 sentence parser between the UART receiver and the LCD1602 controller. It consumes received bytes one at a time and recognises `$xxGGA` sentences. It extracts the latitude field and N/S hemisphere into a stable ASCII register and commits them only after the trailing checksum verifies, so the display never shows a partial or corrupt fix.

---
 rtl/nmea_lat_parser_pkg.sv | 40 ++++
 rtl/nmea_lat_parser_hex_decode.sv | 22 ++
 rtl/nmea_lat_parser.sv | 197 +++++++++++++++++++
 tb/tb_nmea_lat_parser.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/nmea_lat_parser_pkg.sv
// Shared constants for the NMEA sentence parsers: ASCII markers, the GGA
// address match and the FSM state encodings. The longitude and time field
// parsers will reuse the same states.
package nmea_lat_parser_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    // Sentence formatter that follows the two-byte talker ID.
    localparam logic [23:0] GGA_ID       = {8'h47, 8'h47, 8'h41};
    localparam logic [2:0]  HDR_ADDR_LEN = 3'd5;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_HDR       = 4'd1;
    localparam logic [3:0] ST_SKIP_TIME = 4'd2;
    localparam logic [3:0] ST_LAT       = 4'd3;
    localparam logic [3:0] ST_HEMI      = 4'd4;
    localparam logic [3:0] ST_REST      = 4'd5;
    localparam logic [3:0] ST_CK_HI     = 4'd6;
    localparam logic [3:0] ST_CK_LO     = 4'd7;
    localparam logic [3:0] ST_COMMIT    = 4'd8;

    // Expected formatter byte for address positions 2..4.
    function automatic logic [7:0] gga_byte(input logic [2:0] idx);
        case (idx)
            3'd2:    return GGA_ID[23:16];
            3'd3:    return GGA_ID[15:8];
            default: return GGA_ID[7:0];
        endcase
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/nmea_lat_parser_hex_decode.sv
// ASCII hex digit (0-9, A-F, a-f) to nibble, with a flag for legal digits.
module nmea_hex_decode (
    input  logic [7:0] i_char,
    output logic [3:0] o_nibble,
    output logic       o_valid
);

    // Pure lookup; an illegal character yields nibble 0 with o_valid low.
    always_comb begin
        o_nibble = 4'h0;
        o_valid  = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nibble = i_char[3:0];
            o_valid  = 1'b1;
        end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                     (i_char >= 8'h61 && i_char <= 8'h66)) begin
            o_nibble = i_char[3:0] + 4'd9;
            o_valid  = 1'b1;
        end
    end

endmodule

// File: rtl/nmea_lat_parser.sv
// Streaming $xxGGA parser. Latitude and hemisphere are gathered into a shadow
// buffer and copied to the LCD-facing registers only after the checksum
// verifies, so the display never sees a partial or corrupt fix.
module nmea_lat_parser
    import nmea_lat_parser_pkg::*;
#(
    parameter int DATA_BITS = 8,   // must be 8: all byte compares are 8-bit
    parameter int LAT_CHARS = 10
) (
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic [DATA_BITS-1:0]   rx_data,
    input  logic                   rx_valid,
    output logic [LAT_CHARS*8-1:0] lat_ascii,
    output logic [7:0]             lat_hemi,
    output logic                   lat_valid,
    output logic                   no_fix,
    output logic                   cksum_err,
    output logic                   busy
);

    localparam int             CW      = $clog2(LAT_CHARS + 1);
    localparam logic [CW-1:0]  LAT_MAX = CW'(LAT_CHARS);
    localparam logic [CW-1:0]  LAT_ONE = CW'(1);

    logic [3:0]    r_state;
    logic [2:0]    r_hdr_cnt;
    logic [CW-1:0] r_lat_cnt;
    logic          r_hemi_seen;
    logic [7:0]    r_cksum;
    logic [3:0]    r_ck_hi;
    logic          r_ck_ok;
    logic [7:0]    r_shadow_hemi;
    logic [7:0]    r_lat_hemi;
    logic          r_lat_valid;
    logic          r_no_fix;
    logic          r_cksum_err;

    logic [3:0]    w_nibble;
    logic          w_hex_ok;
    logic          w_restart;
    logic          w_lat_wr;
    logic          w_commit_ok;

    nmea_hex_decode u_hex (
        .i_char   (rx_data),
        .o_nibble (w_nibble),
        .o_valid  (w_hex_ok)
    );

    // '$' restarts from any state, including COMMIT, so no byte is lost.
    assign w_restart   = rx_valid && (rx_data == ASCII_DOLLAR);
    assign w_lat_wr    = rx_valid && (r_state == ST_LAT) && !is_eol(rx_data) &&
                         (rx_data != ASCII_DOLLAR) && (rx_data != ASCII_COMMA) &&
                         (r_lat_cnt != LAT_MAX);
    assign w_commit_ok = (r_state == ST_COMMIT) && r_ck_ok && (r_lat_cnt != '0);

    genvar gi;
    generate
        for (gi = 0; gi < LAT_CHARS; gi++) begin : g_char
            logic [7:0] r_shadow_ch;
            logic [7:0] r_lat_ch;

            // Shadow character: cleared on '$', filled in arrival order.
            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset)
                    r_shadow_ch <= ASCII_SPACE;
                else if (w_restart)
                    r_shadow_ch <= ASCII_SPACE;
                else if (w_lat_wr && (r_lat_cnt == CW'(gi)))
                    r_shadow_ch <= rx_data;
            end

            // Displayed character: only moves on a verified, non-empty fix.
            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset)
                    r_lat_ch <= ASCII_SPACE;
                else if (w_commit_ok)
                    r_lat_ch <= r_shadow_ch;
            end

            assign lat_ascii[(LAT_CHARS-1-gi)*8 +: 8] = r_lat_ch;
        end
    endgenerate

    // Sentence FSM, running checksum, field counters and result pulses.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_hdr_cnt     <= 3'd0;
            r_lat_cnt     <= '0;
            r_hemi_seen   <= 1'b0;
            r_cksum       <= 8'h00;
            r_ck_hi       <= 4'h0;
            r_ck_ok       <= 1'b0;
            r_shadow_hemi <= ASCII_SPACE;
            r_lat_hemi    <= ASCII_SPACE;
            r_lat_valid   <= 1'b0;
            r_no_fix      <= 1'b0;
            r_cksum_err   <= 1'b0;
        end else begin
            r_lat_valid <= 1'b0;
            r_no_fix    <= 1'b0;
            r_cksum_err <= 1'b0;

            // COMMIT consumes no byte; a byte arriving now is treated as in IDLE.
            if (r_state == ST_COMMIT) begin
                r_state <= ST_IDLE;
                if (!r_ck_ok)
                    r_cksum_err <= 1'b1;
                else if (r_lat_cnt == '0)
                    r_no_fix <= 1'b1;
                else begin
                    r_lat_valid <= 1'b1;
                    r_lat_hemi  <= r_shadow_hemi;
                end
            end

            if (w_restart) begin
                r_state       <= ST_HDR;
                r_hdr_cnt     <= 3'd0;
                r_lat_cnt     <= '0;
                r_hemi_seen   <= 1'b0;
                r_cksum       <= 8'h00;
                r_shadow_hemi <= ASCII_SPACE;
            end else if (rx_valid && (r_state != ST_IDLE) && (r_state != ST_COMMIT)) begin
                if (is_eol(rx_data)) begin
                    r_state <= ST_IDLE;
                end else begin
                    case (r_state)
                        ST_HDR: begin
                            r_cksum <= r_cksum ^ rx_data;
                            if (r_hdr_cnt == HDR_ADDR_LEN) begin
                                r_state <= (rx_data == ASCII_COMMA) ? ST_SKIP_TIME : ST_IDLE;
                            end else begin
                                if ((r_hdr_cnt >= 3'd2) && (rx_data != gga_byte(r_hdr_cnt)))
                                    r_state <= ST_IDLE;
                                r_hdr_cnt <= r_hdr_cnt + 3'd1;
                            end
                        end
                        ST_SKIP_TIME: begin
                            r_cksum <= r_cksum ^ rx_data;
                            if (rx_data == ASCII_COMMA)
                                r_state <= ST_LAT;
                        end
                        ST_LAT: begin
                            r_cksum <= r_cksum ^ rx_data;
                            if (rx_data == ASCII_COMMA)
                                r_state <= ST_HEMI;
                            else if (w_lat_wr)
                                r_lat_cnt <= r_lat_cnt + LAT_ONE;
                        end
                        ST_HEMI: begin
                            r_cksum <= r_cksum ^ rx_data;
                            if (rx_data == ASCII_COMMA) begin
                                r_state <= ST_REST;
                            end else if (!r_hemi_seen) begin
                                r_shadow_hemi <= rx_data;
                                r_hemi_seen   <= 1'b1;
                            end
                        end
                        ST_REST: begin
                            if (rx_data == ASCII_STAR)
                                r_state <= ST_CK_HI;
                            else
                                r_cksum <= r_cksum ^ rx_data;
                        end
                        ST_CK_HI: begin
                            if (w_hex_ok) begin
                                r_ck_hi <= w_nibble;
                                r_state <= ST_CK_LO;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_CK_LO: begin
                            if (w_hex_ok) begin
                                r_ck_ok <= ({r_ck_hi, w_nibble} == r_cksum);
                                r_state <= ST_COMMIT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign lat_hemi  = r_lat_hemi;
    assign lat_valid = r_lat_valid;
    assign no_fix    = r_no_fix;
    assign cksum_err = r_cksum_err;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_nmea_lat_parser.sv
// Directed bench for nmea_lat_parser: canonical GGA, bad checksum, non-GGA,
// restart mid-sentence, reset mid-sentence, empty latitude and truncation.
module tb_nmea_lat_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [79:0] lat_ascii;
    logic [7:0]  lat_hemi;
    logic        lat_valid, no_fix, cksum_err, busy;

    int checks = 0;
    int errors = 0;

    int n_valid = 0, n_nofix = 0, n_ckerr = 0, n_multi = 0;

    localparam logic [79:0] SPACES  = {10{8'h20}};
    localparam logic [79:0] LAT_STD = "4807.038  ";
    localparam logic [79:0] LAT_TRC = "4807.03812";

    nmea_lat_parser #(.DATA_BITS(8), .LAT_CHARS(10)) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .lat_ascii (lat_ascii),
        .lat_hemi  (lat_hemi),
        .lat_valid (lat_valid),
        .no_fix    (no_fix),
        .cksum_err (cksum_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (lat_valid) n_valid++;
        if (no_fix)    n_nofix++;
        if (cksum_err) n_ckerr++;
        if ((int'(lat_valid) + int'(no_fix) + int'(cksum_err)) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; each byte is captured by the next edge.
    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xsum(input string s);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < s.len(); i++) x = x ^ s[i];
        return x;
    endfunction

    initial begin
        string canon, bad, rmc, cut, empty_body, empty_s, trunc_body, trunc_s, tail;
        int b_valid, b_nofix, b_ckerr;

        canon = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n";
        bad   = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48\r\n";
        rmc   = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n";
        cut   = "$GPGGA,123519,4807.0";
        tail  = "07.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n";
        empty_body = "GPGGA,123519,,,,,0,,,,,,,,";
        empty_s    = {"$", empty_body, "*", $sformatf("%02X", xsum(empty_body)), "\r\n"};
        trunc_body = "GNGGA,1,4807.038123456,S,1,";
        trunc_s    = {"$", trunc_body, "*", $sformatf("%02x", xsum(trunc_body)), "\r\n"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_lat_ascii", lat_ascii, SPACES);
        check("rst_lat_hemi",  80'(lat_hemi), 80'(8'h20));
        check("rst_lat_valid", 80'(lat_valid), 80'(1'b0));
        check("rst_no_fix",    80'(no_fix), 80'(1'b0));
        check("rst_cksum_err", 80'(cksum_err), 80'(1'b0));
        check("rst_busy",      80'(busy), 80'(1'b0));
        reset = 1'b1;
        idle(2);

        // Bad checksum straight after reset: error pulse, outputs stay blank
        b_valid = n_valid; b_ckerr = n_ckerr;
        send(bad, 3); idle(4);
        check("t2_ckerr_cnt", 80'(n_ckerr - b_ckerr), 80'(1));
        check("t2_valid_cnt", 80'(n_valid - b_valid), 80'(0));
        check("t2_lat_ascii", lat_ascii, SPACES);
        check("t2_lat_hemi",  80'(lat_hemi), 80'(8'h20));

        // Canonical sentence, slow byte rate
        b_valid = n_valid; b_ckerr = n_ckerr; b_nofix = n_nofix;
        send(canon, 100); idle(4);
        check("t1_valid_cnt", 80'(n_valid - b_valid), 80'(1));
        check("t1_other_cnt", 80'((n_ckerr - b_ckerr) + (n_nofix - b_nofix)), 80'(0));
        check("t1_lat_ascii", lat_ascii, LAT_STD);
        check("t1_lat_hemi",  80'(lat_hemi), 80'(8'h4E));
        check("t1_busy",      80'(busy), 80'(1'b0));

        // Non-GGA sentence then canonical GGA
        b_valid = n_valid; b_ckerr = n_ckerr; b_nofix = n_nofix;
        send(rmc, 1); idle(4);
        check("t3_rmc_pulses", 80'((n_valid - b_valid) + (n_ckerr - b_ckerr) + (n_nofix - b_nofix)), 80'(0));
        send(canon, 1); idle(4);
        check("t3_gga_valid", 80'(n_valid - b_valid), 80'(1));

        // Cut sentence restarted by '$', back-to-back bytes, latency check
        b_valid = n_valid; b_ckerr = n_ckerr;
        send({cut, canon.substr(0, canon.len() - 3)}, 0);
        check("t4_lat_n1",    80'(lat_valid), 80'(1'b0));
        check("t4_busy_n1",   80'(busy), 80'(1'b1));
        @(posedge clk); #1;
        check("t4_lat_n2",    80'(lat_valid), 80'(1'b1));
        send("\r\n", 0); idle(4);
        check("t4_valid_cnt", 80'(n_valid - b_valid), 80'(1));
        check("t4_ckerr_cnt", 80'(n_ckerr - b_ckerr), 80'(0));
        check("t4_lat_ascii", lat_ascii, LAT_STD);

        // Empty latitude with correct checksum
        b_valid = n_valid; b_nofix = n_nofix;
        send(empty_s, 0); idle(4);
        check("t6_nofix_cnt", 80'(n_nofix - b_nofix), 80'(1));
        check("t6_valid_cnt", 80'(n_valid - b_valid), 80'(0));
        check("t6_lat_ascii", lat_ascii, LAT_STD);

        // Over-long latitude is truncated; lower-case checksum digits
        b_valid = n_valid;
        send(trunc_s, 0); idle(4);
        check("t7_valid_cnt", 80'(n_valid - b_valid), 80'(1));
        check("t7_lat_ascii", lat_ascii, LAT_TRC);
        check("t7_lat_hemi",  80'(lat_hemi), 80'(8'h53));

        // Reset in the middle of the latitude field
        send("$GPGGA,123519,48", 0);
        check("t5_busy_pre", 80'(busy), 80'(1'b1));
        reset = 1'b0;
        #2;
        check("t5_rst_lat_ascii", lat_ascii, SPACES);
        check("t5_rst_lat_hemi",  80'(lat_hemi), 80'(8'h20));
        check("t5_rst_busy",      80'(busy), 80'(1'b0));
        idle(3);
        reset = 1'b1;
        idle(1);
        b_valid = n_valid; b_ckerr = n_ckerr; b_nofix = n_nofix;
        send(tail, 0); idle(4);
        check("t5_tail_pulses", 80'((n_valid - b_valid) + (n_ckerr - b_ckerr) + (n_nofix - b_nofix)), 80'(0));
        check("t5_tail_lat",    lat_ascii, SPACES);
        send(canon, 0); idle(4);
        check("t5_valid_cnt", 80'(n_valid - b_valid), 80'(1));
        check("t5_lat_ascii", lat_ascii, LAT_STD);
        check("t5_lat_hemi",  80'(lat_hemi), 80'(8'h4E));

        check("pulse_exclusive", 80'(n_multi), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
